// File: rtl/ram_loader_if.sv
// Upstream byte-stream handshake between a byte source and ram_loader.
// The source uses the master modport; the loader uses the slave modport.
interface ram_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/ram_loader.sv
// Bootstrap loader that owns the RAM16K write port: it passes the CPU controls
// through when idle, and writes big-endian byte pairs to consecutive addresses during a session.
module ram_loader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    ram_loader_if.slave       bytes,
    input  logic [DATA_W-1:0] cpu_in,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GET_HI = 3'd1;
    localparam logic [2:0] GET_LO = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d  = start_addr;
                        rem_d   = word_count;
                        state_d = GET_HI;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GET_HI: begin
                if (bytes.byte_valid) begin
                    hi_d    = bytes.byte_data;
                    state_d = GET_LO;
                end
            end
            GET_LO: begin
                if (bytes.byte_valid) begin
                    lo_d    = bytes.byte_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Address wraps naturally at 2^ADDR_W.
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == 1) ? DONE : GET_HI;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
        bytes.byte_ready = (state_q == GET_HI) || (state_q == GET_LO);
        if (busy) begin
            ram_in      = {hi_q, lo_q};
            ram_load    = (state_q == WRITE);
            ram_address = addr_q;
        end else begin
            ram_in      = cpu_in;
            ram_load    = cpu_load;
            ram_address = cpu_address;
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural RAM16K model written on ram_load.
module tb_ram_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] start_addr;
    logic [14:0] word_count;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic [13:0] cpu_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [13:0] ram_address;
    logic        busy;
    logic        done;

    ram_loader_if bus ();

    ram_loader #(.ADDR_W(14), .DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .word_count  (word_count),
        .bytes       (bus),
        .cpu_in      (cpu_in),
        .cpu_load    (cpu_load),
        .cpu_address (cpu_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .busy        (busy),
        .done        (done)
    );

    logic [15:0] mem [16384];
    int          load_cnt;
    int          done_cnt;
    int          ready_cnt;
    int          vectors;
    int          miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM16K model plus event counters.
    always @(posedge clk) begin
        if (ram_load) begin
            mem[ram_address] = ram_in;
            load_cnt = load_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        if (bus.byte_ready) ready_cnt = ready_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        load_cnt  = 0;
        done_cnt  = 0;
        ready_cnt = 0;
    endtask

    task automatic pulse_start(input logic [13:0] a, input logic [14:0] n);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the handshake.
    task automatic send_byte(input logic [7:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        n = 0;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!bus.byte_ready) begin
            miscompares++;
            $display("FAIL byte_handshake_timeout: byte_ready=%0b required 1", bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: done=%0b required 1", done);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        cpu_load    = 1'b1;
        cpu_address = 14'd5;
        cpu_in      = 16'hABCD;
        #12;
        vectors++;
        if ({bus.byte_ready, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: ready/busy/done=%b required 000", {bus.byte_ready, busy, done});
        end
        vectors++;
        if ({ram_load, ram_address, ram_in} !== {1'b1, 14'd5, 16'hABCD}) begin
            miscompares++;
            $display("FAIL reset_passthrough: load=%0b addr=%0d in=%h required 1 5 abcd", ram_load, ram_address, ram_in);
        end
        @(negedge clk);
        cpu_load = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_basic();
        clear_counts();
        pulse_start(14'd0, 15'd2);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        vectors++;
        if ({ram_load, ram_address, ram_in, busy} !== {1'b1, 14'd1, 16'h5678, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_write_cycle: load=%0b addr=%0d in=%h busy=%0b required 1 1 5678 1", ram_load, ram_address, ram_in, busy);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, ram_load} !== 3'b110) begin
            miscompares++;
            $display("FAIL basic_done_cycle: done/busy/load=%b required 110", {done, busy, ram_load});
        end
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_idle_after: done/busy=%b required 00", {done, busy});
        end
        vectors++;
        if (mem[0] !== 16'h1234 || mem[1] !== 16'h5678) begin
            miscompares++;
            $display("FAIL basic_ram: ram0=%h ram1=%h required 1234 5678", mem[0], mem[1]);
        end
        vectors++;
        if (load_cnt !== 2 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL basic_counts: loads=%0d dones=%0d required 2 1", load_cnt, done_cnt);
        end
    endtask

    task automatic test_wrap();
        mem[1] = 16'hBEEF;
        clear_counts();
        pulse_start(14'd16383, 15'd2);
        send_byte(8'hAA, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        send_byte(8'h55, 0);
        wait_done();
        @(negedge clk);
        vectors++;
        if (mem[16383] !== 16'hAAAA || mem[0] !== 16'h5555 || mem[1] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL wrap_ram: ram16383=%h ram0=%h ram1=%h required aaaa 5555 beef", mem[16383], mem[0], mem[1]);
        end
    endtask

    task automatic test_zero_length();
        clear_counts();
        pulse_start(14'd500, 15'd0);
        vectors++;
        if ({done, busy, bus.byte_ready, ram_load} !== 4'b1100) begin
            miscompares++;
            $display("FAIL zero_done_cycle: done/busy/ready/load=%b required 1100", {done, busy, bus.byte_ready, ram_load});
        end
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_idle_after: done/busy=%b required 00", {done, busy});
        end
        vectors++;
        if (load_cnt !== 0 || ready_cnt !== 0 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL zero_counts: loads=%0d readys=%0d dones=%0d required 0 0 1", load_cnt, ready_cnt, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        mem[7]   = 16'h0777;
        mem[200] = 16'h0000;
        clear_counts();
        pulse_start(14'd100, 15'd3);
        cpu_load    = 1'b1;
        cpu_address = 14'd7;
        cpu_in      = 16'hFFFF;
        send_byte(8'hA1, 2);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 3);
        // Mid-session start pulse with different parameters.
        start      = 1'b1;
        start_addr = 14'd200;
        word_count = 15'd1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hD4, 1);
        send_byte(8'hE5, 0);
        send_byte(8'hF6, 2);
        wait_done();
        cpu_load = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem[100] !== 16'hA1B2 || mem[101] !== 16'hC3D4 || mem[102] !== 16'hE5F6) begin
            miscompares++;
            $display("FAIL bp_ram: ram100=%h ram101=%h ram102=%h required a1b2 c3d4 e5f6", mem[100], mem[101], mem[102]);
        end
        vectors++;
        if (mem[7] !== 16'h0777 || mem[200] !== 16'h0000) begin
            miscompares++;
            $display("FAIL bp_ignored: ram7=%h ram200=%h required 0777 0000", mem[7], mem[200]);
        end
        vectors++;
        if (load_cnt !== 3 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL bp_counts: loads=%0d dones=%0d required 3 1", load_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        mem[50] = 16'h0000;
        mem[16] = 16'hFFFF;
        clear_counts();
        pulse_start(14'd50, 15'd1);
        send_byte(8'h99, 0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.byte_ready, busy, done, ram_load} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_outputs: ready/busy/done/load=%b required 0000", {bus.byte_ready, busy, done, ram_load});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (load_cnt !== 0 || mem[50] !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_nowrite: loads=%0d ram50=%h required 0 0000", load_cnt, mem[50]);
        end
        pulse_start(14'd16, 15'd1);
        send_byte(8'h00, 0);
        send_byte(8'h16, 0);
        wait_done();
        @(negedge clk);
        vectors++;
        if (mem[16] !== 16'h0016 || load_cnt !== 1) begin
            miscompares++;
            $display("FAIL midreset_reload: ram16=%h loads=%0d required 0016 1", mem[16], load_cnt);
        end
    endtask

    task automatic test_passthrough();
        clear_counts();
        @(negedge clk);
        cpu_load    = 1'b1;
        cpu_address = 14'd1111;
        cpu_in      = 16'h1111;
        #1;
        vectors++;
        if ({ram_load, ram_address, ram_in} !== {1'b1, 14'd1111, 16'h1111}) begin
            miscompares++;
            $display("FAIL pass_drive: load=%0b addr=%0d in=%h required 1 1111 1111", ram_load, ram_address, ram_in);
        end
        @(negedge clk);
        cpu_load = 1'b0;
        cpu_in   = 16'h0000;
        #1;
        vectors++;
        if (mem[ram_address] !== 16'h1111 || ram_load !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_read: ram_out=%h load=%0b required 1111 0", mem[ram_address], ram_load);
        end
        vectors++;
        if (busy !== 1'b0 || ready_cnt !== 0 || load_cnt !== 1) begin
            miscompares++;
            $display("FAIL pass_flags: busy=%0b readys=%0d loads=%0d required 0 0 1", busy, ready_cnt, load_cnt);
        end
    endtask

    initial begin
        for (int unsigned i = 0; i < 16384; i++) mem[i] = 16'h0000;
        vectors        = 0;
        miscompares    = 0;
        load_cnt       = 0;
        done_cnt       = 0;
        ready_cnt      = 0;
        start          = 1'b0;
        start_addr     = '0;
        word_count     = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        cpu_in         = '0;
        cpu_load       = 1'b0;
        cpu_address    = '0;

        test_reset();
        test_basic();
        test_wrap();
        test_zero_length();
        test_backpressure();
        test_reset_mid();
        test_passthrough();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
